// File: rtl/axi_rd_xfer_engine.sv
// Purpose: AXI4 read engine serving four submasters, one INCR burst at a time, sel from a one-hot grant.
// Latency: grant -> arvalid 1 cycle; R beats pass through combinationally; last beat -> xfer_done 1 cycle.
// Backpressure: rready is the selected submaster's ready; AR holds address/length until arready.
module axi_rd_xfer_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            grant,
    input  logic [4*ADDR_W-1:0]   sub_addr,
    input  logic [31:0]           sub_len,
    output logic [3:0]            xfer_done,
    output logic                  xfer_err,
    output logic [3:0]            sub_rd_valid,
    input  logic [3:0]            sub_rd_ready,
    output logic [DATA_W-1:0]     sub_rd_data,
    output logic                  sub_rd_last,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast
);

    localparam logic [2:0] LP_ARSIZE = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t              r_state;
    logic [1:0]          r_sel;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_len;
    logic [7:0]          r_beat_cnt;
    logic                r_err;
    logic                r_arvalid;
    logic [3:0]          r_done;
    logic                r_done_err;

    logic [1:0]          w_sel;
    logic                w_in_data;
    logic                w_hs;
    logic                w_cnt_eq;
    logic                w_end;
    logic                w_beat_err;
    logic                w_unused;

    // Lowest set grant bit wins when several submasters are granted at once.
    always_comb begin
        w_sel = 2'd0;
        if (grant[0])      w_sel = 2'd0;
        else if (grant[1]) w_sel = 2'd1;
        else if (grant[2]) w_sel = 2'd2;
        else if (grant[3]) w_sel = 2'd3;
    end

    assign w_in_data  = (r_state == S_DATA);
    assign w_hs       = w_in_data & rvalid & sub_rd_ready[r_sel];
    assign w_cnt_eq   = (r_beat_cnt == r_len);
    // Burst ends on whichever comes first: slave rlast or our own beat count reaching arlen.
    assign w_end      = w_hs & (rlast | w_cnt_eq);
    // Error response, or slave's rlast disagreeing with the requested length.
    assign w_beat_err = w_hs & (rresp[1] | (rlast ^ w_cnt_eq));
    // Only rresp[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    assign w_unused   = rresp[0];

    assign arvalid     = r_arvalid;
    assign araddr      = r_addr;
    assign arlen       = r_len;
    assign arsize      = LP_ARSIZE;
    assign arburst     = 2'b01;
    assign xfer_done   = r_done;
    assign xfer_err    = r_done_err;
    assign rready      = w_in_data & sub_rd_ready[r_sel];
    assign sub_rd_data = w_in_data ? rdata : '0;
    assign sub_rd_last = w_in_data & rlast;

    // Route the R valid only to the submaster that owns the current burst.
    always_comb begin
        sub_rd_valid = 4'b0000;
        if (w_in_data) begin
            sub_rd_valid[r_sel] = rvalid;
        end
    end

    // Transfer FSM: latch request, issue AR, count R beats, pulse completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sel      <= 2'd0;
            r_addr     <= '0;
            r_len      <= 8'd0;
            r_beat_cnt <= 8'd0;
            r_err      <= 1'b0;
            r_arvalid  <= 1'b0;
            r_done     <= 4'b0000;
            r_done_err <= 1'b0;
        end else begin
            r_done     <= 4'b0000;
            r_done_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|grant) begin
                        r_sel     <= w_sel;
                        r_addr    <= sub_addr[int'(w_sel)*ADDR_W +: ADDR_W];
                        r_len     <= sub_len[int'(w_sel)*8 +: 8];
                        r_err     <= 1'b0;
                        r_arvalid <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (arready) begin
                        r_arvalid  <= 1'b0;
                        r_beat_cnt <= 8'd0;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (w_beat_err) begin
                            r_err <= 1'b1;
                        end
                        if (w_end) begin
                            r_done[r_sel] <= 1'b1;
                            r_done_err    <= r_err | w_beat_err;
                            r_state       <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
